// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator: serialises {addr, data} frames MSB first and
// returns the MISO byte captured during the data byte as a response.
module spi_reg_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 2
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [7:0] req_addr_i,
    input  logic [7:0] req_data_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       busy_o,
    output logic       spi_clk_o,
    output logic       spi_mosi_o,
    output logic       spi_ncs_o,
    input  logic       spi_miso_i
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned FRAME_W = 2 * BYTE_W;
    localparam int unsigned BIT_W   = 5;

    // One phase counter serves divider, setup, hold and gap timing
    localparam int unsigned MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_CD  = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_IDLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] DATA_FIRST = BIT_W'(BYTE_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [FRAME_W-1:0]   tx_q, tx_d;
    logic [BYTE_W-1:0]    rx_q, rx_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 ncs_q, ncs_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [BYTE_W-1:0]    rsp_data_q, rsp_data_d;

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ncs_q       <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            ncs_q       <= ncs_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        ncs_d       = ncs_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i && ready_q) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = {req_addr_i, req_data_i};
                    rx_d    = '0;
                    ncs_d   = 1'b0;
                    mosi_d  = req_addr_i[BYTE_W-1];
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SHIFT: begin
                if (cnt_q != DIV_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        // Rising SCLK: slave data is stable, keep only the data byte
                        sclk_d = 1'b1;
                        if (bit_q >= DATA_FIRST) begin
                            rx_d = {rx_q[BYTE_W-2:0], spi_miso_i};
                        end
                    end else begin
                        // Falling SCLK: advance MOSI or close the frame
                        sclk_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            state_d = ST_HOLD;
                            mosi_d  = 1'b0;
                        end else begin
                            bit_d  = bit_q + BIT_W'(1);
                            tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
                            mosi_d = tx_q[FRAME_W-2];
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d     = ST_GAP;
                    cnt_d       = '0;
                    ncs_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    bit_d   = '0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                ncs_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = busy_q;
    assign spi_clk_o   = sclk_q;
    assign spi_mosi_o  = mosi_q;
    assign spi_ncs_o   = ncs_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master: a CLK_DIV=2 and a CLK_DIV=1 instance,
// each with a mode-0 slave model that decodes MOSI and drives MISO.
module tb_spi_reg_master;

    localparam int NDUT = 2;

    logic       clk;
    logic       nrst      [NDUT];
    logic       req_valid [NDUT];
    logic       req_ready [NDUT];
    logic [7:0] req_addr  [NDUT];
    logic [7:0] req_data  [NDUT];
    logic       rsp_valid [NDUT];
    logic [7:0] rsp_data  [NDUT];
    logic       busy      [NDUT];
    logic       sclk      [NDUT];
    logic       mosi      [NDUT];
    logic       ncs       [NDUT];
    logic       miso      [NDUT];

    int vectors;
    int errors;

    // slave model / monitor state
    int         cyc;
    logic       prev_ncs  [NDUT];
    logic       prev_sclk [NDUT];
    logic       prev_rv   [NDUT];
    int         rises     [NDUT];
    int         falls     [NDUT];
    int         low_cnt   [NDUT];
    int         hi_cnt    [NDUT];
    int         gap_last  [NDUT];
    int         per_min   [NDUT];
    int         per_max   [NDUT];
    int         last_rise [NDUT];
    logic [15:0] word     [NDUT];
    logic [15:0] fr_word  [NDUT][32];
    int         fr_cnt    [NDUT];
    int         rsp_cnt   [NDUT];
    int         rsp_wide  [NDUT];
    logic [7:0] rsp_last  [NDUT];
    int         acc_cyc   [NDUT][8];
    int         acc_n     [NDUT];
    logic [7:0] tx        [NDUT];

    spi_reg_master #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)) u_div2 (
        .clk_i(clk), .nrst_i(nrst[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_addr_i(req_addr[0]), .req_data_i(req_data[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_data_o(rsp_data[0]), .busy_o(busy[0]),
        .spi_clk_o(sclk[0]), .spi_mosi_o(mosi[0]), .spi_ncs_o(ncs[0]), .spi_miso_i(miso[0])
    );

    spi_reg_master #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)) u_div1 (
        .clk_i(clk), .nrst_i(nrst[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_addr_i(req_addr[1]), .req_data_i(req_data[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_data_o(rsp_data[1]), .busy_o(busy[1]),
        .spi_clk_o(sclk[1]), .spi_mosi_o(mosi[1]), .spi_ncs_o(ncs[1]), .spi_miso_i(miso[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave model and bus monitor, sampled on the falling clock edge
    initial begin
        cyc = 0;
        for (int i = 0; i < NDUT; i++) begin
            prev_ncs[i] = 1'b1; prev_sclk[i] = 1'b0; prev_rv[i] = 1'b0;
            rises[i] = 0; falls[i] = 0; low_cnt[i] = 0; hi_cnt[i] = 0; gap_last[i] = 0;
            per_min[i] = 1000; per_max[i] = 0; last_rise[i] = 0; word[i] = '0;
            fr_cnt[i] = 0; rsp_cnt[i] = 0; rsp_wide[i] = 0; rsp_last[i] = '0;
            acc_n[i] = 0; tx[i] = '0; miso[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NDUT; i++) begin
                if (req_valid[i] && req_ready[i] && nrst[i]) begin
                    if (acc_n[i] < 8) acc_cyc[i][acc_n[i]] = cyc;
                    acc_n[i]++;
                end
                if (rsp_valid[i] && !prev_rv[i]) begin
                    rsp_cnt[i]++;
                    rsp_last[i] = rsp_data[i];
                end
                if (rsp_valid[i] && prev_rv[i]) rsp_wide[i]++;
                prev_rv[i] = rsp_valid[i];

                if (prev_ncs[i] && !ncs[i]) begin
                    gap_last[i] = hi_cnt[i];
                    rises[i] = 0; falls[i] = 0; low_cnt[i] = 0; word[i] = '0;
                    per_min[i] = 1000; per_max[i] = 0;
                end
                if (!ncs[i]) begin
                    low_cnt[i]++;
                    hi_cnt[i] = 0;
                    if (!prev_sclk[i] && sclk[i]) begin
                        word[i] = {word[i][14:0], mosi[i]};
                        if (rises[i] > 0) begin
                            if (cyc - last_rise[i] < per_min[i]) per_min[i] = cyc - last_rise[i];
                            if (cyc - last_rise[i] > per_max[i]) per_max[i] = cyc - last_rise[i];
                        end
                        last_rise[i] = cyc;
                        rises[i]++;
                    end
                    if (prev_sclk[i] && !sclk[i]) falls[i]++;
                end else begin
                    hi_cnt[i]++;
                end
                if (!prev_ncs[i] && ncs[i]) begin
                    if (fr_cnt[i] < 32) fr_word[i][fr_cnt[i]] = word[i];
                    fr_cnt[i]++;
                end
                prev_ncs[i]  = ncs[i];
                prev_sclk[i] = sclk[i];
                // mode 0: present the next response bit after each falling edge
                if (!ncs[i] && falls[i] >= 8 && falls[i] < 16)
                    miso[i] = tx[i][3'(15 - falls[i])];
                else
                    miso[i] = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic start_req(input int i, input logic [7:0] a, input logic [7:0] d);
        bit acc;
        acc = 1'b0;
        @(posedge clk); #1;
        req_addr[i] = a; req_data[i] = d; req_valid[i] = 1'b1;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk); #1;
            if (req_ready[i]) acc = 1'b1;
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        vectors++;
        if (!acc) begin
            errors++;
            $display("FAIL accept dut%0d: ready=0 for 300 cycles, required ready=1", i);
        end
    endtask

    task automatic wait_rsp(input int i, input int prev);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk); #1;
            if (rsp_cnt[i] > prev) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL rsp_timeout dut%0d: no rsp_valid within 400 cycles, required a pulse", i);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NDUT; i++) begin
            nrst[i] = 1'b0; req_valid[i] = 1'b1; req_addr[i] = 8'h5A; req_data[i] = 8'hC3;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            vectors++; if (ncs[i] !== 1'b1) begin errors++; $display("FAIL reset_ncs dut%0d: got %b required 1", i, ncs[i]); end
            vectors++; if (sclk[i] !== 1'b0) begin errors++; $display("FAIL reset_sclk dut%0d: got %b required 0", i, sclk[i]); end
            vectors++; if (mosi[i] !== 1'b0) begin errors++; $display("FAIL reset_mosi dut%0d: got %b required 0", i, mosi[i]); end
            vectors++; if (req_ready[i] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d: got %b required 1", i, req_ready[i]); end
            vectors++; if (busy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b required 0", i, busy[i]); end
            vectors++; if (rsp_valid[i] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid dut%0d: got %b required 0", i, rsp_valid[i]); end
            vectors++; if (rsp_data[i] !== 8'h00) begin errors++; $display("FAIL reset_rsp_data dut%0d: got %h required 00", i, rsp_data[i]); end
        end
        @(posedge clk); #1;
        for (int i = 0; i < NDUT; i++) req_valid[i] = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NDUT; i++) nrst[i] = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        int r0, w0, f0;
        r0 = rsp_cnt[0]; w0 = rsp_wide[0]; f0 = fr_cnt[0];
        tx[0] = 8'h00;
        start_req(0, 8'h01, 8'h80);
        wait_rsp(0, r0);
        vectors++; if (word[0] !== 16'h0180) begin errors++; $display("FAIL basic_word: got %h required 0180", word[0]); end
        vectors++; if (rises[0] !== 16) begin errors++; $display("FAIL basic_rises: got %0d required 16", rises[0]); end
        vectors++; if (low_cnt[0] !== 68) begin errors++; $display("FAIL basic_ncs_low: got %0d required 68", low_cnt[0]); end
        vectors++; if (rsp_cnt[0] !== r0 + 1) begin errors++; $display("FAIL basic_rsp_count: got %0d required %0d", rsp_cnt[0], r0 + 1); end
        vectors++; if (rsp_wide[0] !== w0) begin errors++; $display("FAIL basic_rsp_width: got %0d extra cycles required %0d", rsp_wide[0], w0); end
        vectors++; if (fr_cnt[0] !== f0 + 1) begin errors++; $display("FAIL basic_frames: got %0d required %0d", fr_cnt[0], f0 + 1); end
        repeat (3) @(negedge clk);
        #1;
        vectors++; if (mosi[0] !== 1'b0) begin errors++; $display("FAIL basic_mosi_idle: got %b required 0", mosi[0]); end
        vectors++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b required 0", busy[0]); end
        vectors++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL basic_ready_idle: got %b required 1", req_ready[0]); end
    endtask

    task automatic test_readback();
        int r0, w0;
        r0 = rsp_cnt[0]; w0 = rsp_wide[0];
        tx[0] = 8'hA5;
        start_req(0, 8'h02, 8'h3C);
        wait_rsp(0, r0);
        vectors++; if (rsp_last[0] !== 8'hA5) begin errors++; $display("FAIL readback_data: got %h required a5", rsp_last[0]); end
        vectors++; if (word[0] !== 16'h023C) begin errors++; $display("FAIL readback_word: got %h required 023c", word[0]); end
        vectors++; if (rsp_wide[0] !== w0) begin errors++; $display("FAIL readback_rsp_width: got %0d extra cycles required %0d", rsp_wide[0], w0); end
        repeat (10) @(negedge clk);
        #1;
        vectors++; if (rsp_data[0] !== 8'hA5) begin errors++; $display("FAIL readback_hold: got %h required a5", rsp_data[0]); end
    endtask

    task automatic test_back_to_back();
        int r0, f0, a0;
        bit acc;
        r0 = rsp_cnt[0]; f0 = fr_cnt[0]; a0 = acc_n[0];
        tx[0] = 8'h00;
        @(posedge clk); #1;
        req_addr[0] = 8'h00; req_data[0] = 8'h03; req_valid[0] = 1'b1;
        for (int n = 0; n < 2; n++) begin
            acc = 1'b0;
            for (int k = 0; k < 300 && !acc; k++) begin
                @(negedge clk); #1;
                if (req_ready[0]) acc = 1'b1;
            end
            vectors++;
            if (!acc) begin errors++; $display("FAIL b2b_accept%0d: ready=0 for 300 cycles, required ready=1", n); end
            @(posedge clk); #1;
            req_addr[0] = 8'h03; req_data[0] = 8'hFF;
        end
        req_valid[0] = 1'b0;
        wait_rsp(0, r0 + 1);
        vectors++; if (fr_cnt[0] !== f0 + 2) begin errors++; $display("FAIL b2b_frames: got %0d required %0d", fr_cnt[0], f0 + 2); end
        vectors++; if (fr_word[0][f0] !== 16'h0003) begin errors++; $display("FAIL b2b_first_word: got %h required 0003", fr_word[0][f0]); end
        vectors++; if (fr_word[0][f0 + 1] !== 16'h03FF) begin errors++; $display("FAIL b2b_second_word: got %h required 03ff", fr_word[0][f0 + 1]); end
        vectors++; if (acc_cyc[0][a0 + 1] - acc_cyc[0][a0] !== 71) begin errors++; $display("FAIL b2b_accept_spacing: got %0d required 71", acc_cyc[0][a0 + 1] - acc_cyc[0][a0]); end
        vectors++; if (gap_last[0] !== 3) begin errors++; $display("FAIL b2b_ncs_gap: got %0d required 3", gap_last[0]); end
        vectors++; if (rsp_cnt[0] !== r0 + 2) begin errors++; $display("FAIL b2b_rsp_count: got %0d required %0d", rsp_cnt[0], r0 + 2); end
    endtask

    task automatic test_reset_midframe();
        int r0;
        bit hit;
        r0 = rsp_cnt[0];
        tx[0] = 8'hFF;
        start_req(0, 8'hC3, 8'h5A);
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk); #1;
            if (rises[0] >= 5) hit = 1'b1;
        end
        vectors++; if (!hit) begin errors++; $display("FAIL midreset_rises: got %0d rises required 5", rises[0]); end
        nrst[0] = 1'b0;
        #1;
        vectors++; if (ncs[0] !== 1'b1) begin errors++; $display("FAIL midreset_ncs: got %b required 1", ncs[0]); end
        vectors++; if (sclk[0] !== 1'b0) begin errors++; $display("FAIL midreset_sclk: got %b required 0", sclk[0]); end
        vectors++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy[0]); end
        @(posedge clk); #1;
        nrst[0] = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        vectors++; if (rsp_cnt[0] !== r0) begin errors++; $display("FAIL midreset_no_rsp: got %0d pulses required %0d", rsp_cnt[0], r0); end
        vectors++; if (rises[0] !== 5) begin errors++; $display("FAIL midreset_abort_rises: got %0d required 5", rises[0]); end
        tx[0] = 8'h00;
        start_req(0, 8'h01, 8'h55);
        wait_rsp(0, r0);
        vectors++; if (word[0] !== 16'h0155) begin errors++; $display("FAIL midreset_next_word: got %h required 0155", word[0]); end
        vectors++; if (rises[0] !== 16) begin errors++; $display("FAIL midreset_next_rises: got %0d required 16", rises[0]); end
        vectors++; if (low_cnt[0] !== 68) begin errors++; $display("FAIL midreset_next_ncs_low: got %0d required 68", low_cnt[0]); end
    endtask

    task automatic test_div1();
        int r0;
        r0 = rsp_cnt[1];
        tx[1] = 8'h5A;
        start_req(1, 8'hFF, 8'h00);
        wait_rsp(1, r0);
        vectors++; if (word[1] !== 16'hFF00) begin errors++; $display("FAIL div1_word_a: got %h required ff00", word[1]); end
        vectors++; if (rises[1] !== 16) begin errors++; $display("FAIL div1_rises: got %0d required 16", rises[1]); end
        vectors++; if (per_min[1] !== 2 || per_max[1] !== 2) begin errors++; $display("FAIL div1_sclk_period: got min %0d max %0d required 2", per_min[1], per_max[1]); end
        vectors++; if (low_cnt[1] !== 36) begin errors++; $display("FAIL div1_ncs_low: got %0d required 36", low_cnt[1]); end
        vectors++; if (rsp_last[1] !== 8'h5A) begin errors++; $display("FAIL div1_readback_a: got %h required 5a", rsp_last[1]); end
        r0 = rsp_cnt[1];
        tx[1] = 8'hC3;
        start_req(1, 8'h00, 8'hFF);
        wait_rsp(1, r0);
        vectors++; if (word[1] !== 16'h00FF) begin errors++; $display("FAIL div1_word_b: got %h required 00ff", word[1]); end
        vectors++; if (rsp_last[1] !== 8'hC3) begin errors++; $display("FAIL div1_readback_b: got %h required c3", rsp_last[1]); end
        vectors++; if (rsp_wide[1] !== 0) begin errors++; $display("FAIL div1_rsp_width: got %0d extra cycles required 0", rsp_wide[1]); end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        for (int i = 0; i < NDUT; i++) begin
            nrst[i] = 1'b0; req_valid[i] = 1'b0; req_addr[i] = '0; req_data[i] = '0;
        end
        test_reset();
        test_basic();
        test_readback();
        test_back_to_back();
        test_reset_midframe();
        test_div1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
